// File: rtl/flash_mp_region_scan_pkg.sv
// Shared types for the sequential flash data-region scanner.
package flash_mp_region_scan_pkg;

    // Page-address width of the flash array.
    localparam int unsigned AllPagesW = 9;

    typedef enum logic [1:0] {
        PhaseSeed    = 2'd0,
        PhaseRma     = 2'd1,
        PhaseNone    = 2'd2,
        PhaseInvalid = 2'd3
    } flash_lcmgr_phase_e;

    typedef struct packed {
        logic                 en;
        logic                 rd_en;
        logic                 prog_en;
        logic                 erase_en;
        logic                 scramble_en;
        logic                 ecc_en;
        logic                 he_en;
        logic [AllPagesW-1:0] base;
        logic [AllPagesW:0]   size;
    } mp_region_cfg_t;

    typedef struct packed {
        flash_lcmgr_phase_e phase;
        mp_region_cfg_t     cfg;
    } data_region_attr_t;

    typedef enum logic [1:0] {
        ScanIdle = 2'd0,
        ScanBusy = 2'd1,
        ScanDone = 2'd2
    } flash_mp_scan_st_e;

    // Index width that stays at least one bit for a single entry.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/flash_mp_region_cmp.sv
// Single-region address/phase comparator.
module flash_mp_region_cmp
    import flash_mp_region_scan_pkg::*;
#(
    parameter int unsigned AddrW = AllPagesW
) (
    input  logic [AddrW-1:0] addr,
    input  flash_lcmgr_phase_e phase,
    input  data_region_attr_t attr,
    output logic             match_c
);

    // Two guard bits so base+size can never wrap back into the page range.
    localparam int unsigned CmpW = ((AddrW > AllPagesW) ? AddrW : AllPagesW) + 2;

    logic [CmpW-1:0] addr_ext;
    logic [CmpW-1:0] base_ext;
    logic [CmpW-1:0] end_ext;

    // Half-open range check [base, base+size); size 0 is an empty range.
    always_comb begin
        addr_ext = CmpW'(addr);
        base_ext = CmpW'(attr.cfg.base);
        end_ext  = base_ext + CmpW'(attr.cfg.size);
        match_c  = attr.cfg.en
                 && (addr_ext >= base_ext)
                 && (addr_ext < end_ext)
                 && (phase == attr.phase);
    end

endmodule

// File: rtl/flash_mp_region_scan.sv
// Sequential priority scan over the flash data regions, a batch per beat.
module flash_mp_region_scan
    import flash_mp_region_scan_pkg::*;
#(
    parameter int unsigned Regions         = 8,
    parameter int unsigned RegionsPerCycle = 2,
    parameter int unsigned AddrW           = AllPagesW,
    localparam int unsigned RegIdxW        = idx_width(Regions)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_i,
    output logic               ready_o,
    input  flash_lcmgr_phase_e phase_i,
    input  logic [AddrW-1:0]   addr_i,
    input  data_region_attr_t  region_attrs_i [Regions],
    input  mp_region_cfg_t     default_cfg_i,
    output logic               valid_o,
    output logic               hit_o,
    output logic [RegIdxW-1:0] idx_o,
    output mp_region_cfg_t     sel_cfg_o
);

    localparam int unsigned Batches = Regions / RegionsPerCycle;
    localparam int unsigned BatchW  = idx_width(Batches);
    localparam logic [BatchW-1:0] LastBatch = BatchW'(Batches - 1);

    // Reject geometries that cannot be split into whole batches.
    if (RegionsPerCycle < 1) begin : gen_bad_rpc
        $error("RegionsPerCycle must be at least 1");
    end else if ((Regions % RegionsPerCycle) != 0) begin : gen_bad_div
        $error("RegionsPerCycle must divide Regions");
    end

    flash_mp_scan_st_e  state_q, state_d;
    logic [BatchW-1:0]  batch_q, batch_d;
    logic [AddrW-1:0]   addr_q;
    flash_lcmgr_phase_e phase_q;
    mp_region_cfg_t     default_q;
    logic               capture_c;

    logic               ready_q, ready_d;
    logic               valid_q, valid_d;
    logic               hit_q, hit_d;
    logic [RegIdxW-1:0] idx_q, idx_d;
    mp_region_cfg_t     cfg_q, cfg_d;

    data_region_attr_t  lane_attr  [RegionsPerCycle];
    logic [RegIdxW-1:0] lane_idx   [RegionsPerCycle];
    logic               lane_match [RegionsPerCycle];

    logic               batch_hit_c;
    logic [RegIdxW-1:0] batch_idx_c;
    mp_region_cfg_t     batch_cfg_c;

    // Route the current batch of live region attributes onto the comparator lanes.
    always_comb begin
        for (int unsigned j = 0; j < RegionsPerCycle; j++) begin
            lane_attr[j] = '0;
            lane_idx[j]  = '0;
        end
        for (int unsigned b = 0; b < Batches; b++) begin
            if (batch_q == BatchW'(b)) begin
                for (int unsigned j = 0; j < RegionsPerCycle; j++) begin
                    lane_attr[j] = region_attrs_i[b * RegionsPerCycle + j];
                    lane_idx[j]  = RegIdxW'(b * RegionsPerCycle + j);
                end
            end
        end
    end

    for (genvar g = 0; g < RegionsPerCycle; g++) begin : gen_lane
        flash_mp_region_cmp #(
            .AddrW (AddrW)
        ) u_cmp (
            .addr    (addr_q),
            .phase   (phase_q),
            .attr    (lane_attr[g]),
            .match_c (lane_match[g])
        );
    end

    // Lowest matching lane in the batch wins; scanning high-to-low lets it overwrite.
    always_comb begin
        batch_hit_c = 1'b0;
        batch_idx_c = '0;
        batch_cfg_c = '0;
        for (int j = int'(RegionsPerCycle) - 1; j >= 0; j--) begin
            if (lane_match[j]) begin
                batch_hit_c = 1'b1;
                batch_idx_c = lane_idx[j];
                batch_cfg_c = lane_attr[j].cfg;
            end
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ScanIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, batch advance and result selection.
    always_comb begin
        state_d   = state_q;
        batch_d   = batch_q;
        capture_c = 1'b0;
        hit_d     = hit_q;
        idx_d     = idx_q;
        cfg_d     = cfg_q;
        unique case (state_q)
            ScanIdle: begin
                if (req_i) begin
                    capture_c = 1'b1;
                    batch_d   = '0;
                    state_d   = ScanBusy;
                end
            end
            ScanBusy: begin
                if (batch_hit_c) begin
                    hit_d   = 1'b1;
                    idx_d   = batch_idx_c;
                    cfg_d   = batch_cfg_c;
                    state_d = ScanDone;
                end else if (batch_q == LastBatch) begin
                    hit_d   = 1'b0;
                    idx_d   = '0;
                    cfg_d   = default_q;
                    state_d = ScanDone;
                end else begin
                    batch_d = batch_q + BatchW'(1);
                end
            end
            ScanDone: begin
                state_d = ScanIdle;
            end
            default: begin
                state_d = ScanIdle;
            end
        endcase
        ready_d = (state_d == ScanIdle);
        valid_d = (state_d == ScanDone);
    end

    // Request capture, batch counter and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            batch_q   <= '0;
            addr_q    <= '0;
            phase_q   <= PhaseSeed;
            default_q <= '0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            hit_q     <= 1'b0;
            idx_q     <= '0;
            cfg_q     <= '0;
        end else begin
            batch_q <= batch_d;
            if (capture_c) begin
                addr_q    <= addr_i;
                phase_q   <= phase_i;
                default_q <= default_cfg_i;
            end
            ready_q <= ready_d;
            valid_q <= valid_d;
            hit_q   <= hit_d;
            idx_q   <= idx_d;
            cfg_q   <= cfg_d;
        end
    end

    assign ready_o   = ready_q;
    assign valid_o   = valid_q;
    assign hit_o     = hit_q;
    assign idx_o     = idx_q;
    assign sel_cfg_o = cfg_q;

    // Result pulse is single-cycle and never overlaps the idle indication.
    a_valid_pulse: assert property (@(posedge clk_i) disable iff (rst_i) valid_o |=> !valid_o);
    a_ready_valid: assert property (@(posedge clk_i) disable iff (rst_i) !(ready_o && valid_o));

endmodule

// File: doc/flash_mp_region_scan.md
# flash_mp_region_scan

Sequential, parametrised successor to the combinational flash data-region selector in flash_ctrl's memory-protection path. It scans the data-region attribute set RegionsPerCycle entries per clock, lowest index first, so comparator depth is independent of region count. It resolves priority with early exit, falls back to a supplied default config on a miss, and returns the selected config, matched index and hit flag through a req/ready/valid handshake. It sits between the flash_ctrl request arbiter and the protocol controller's permission check.

## Interface
- Regions, 8: number of data regions; must be at least 1.
- RegionsPerCycle, 2: regions compared per scan beat; must divide Regions exactly (elaboration assertion).
- AddrW, AllPagesW: page-address width.
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high; one clock, all state sampled on clk_i rising edge.
- req_i  in  1  lookup request; accepted when req_i & ready_o.
- ready_o  out  1  block idle, able to accept.
- phase_i  in  flash_lcmgr_phase_e  requesting phase; sampled at accept.
- addr_i  in  AddrW  page address; sampled at accept.
- region_attrs_i  in  data_region_attr_t [Regions]  region cfgs (en, base, size) plus phase; read live each beat.
- default_cfg_i  in  mp_region_cfg_t  config returned on miss; sampled at accept.
- valid_o  out  1  one-cycle result pulse.
- hit_o  out  1  a region matched.
- idx_o  out  RegIdxW  matched region index; 0 on miss.
- sel_cfg_o  out  mp_region_cfg_t  selected config, or default on miss.

## Operation
- States: Idle, Scan, Done.
- Idle:
  - ready_o=1.
  - On req_i: capture addr, phase and default cfg; batch counter b=0; go to Scan.
- Scan: compare regions b*RegionsPerCycle .. b*RegionsPerCycle+RegionsPerCycle-1.
  - Match rule for region i: en & addr >= base & {1'b0,addr} < ({1'b0,base}+size) & phase == attr.phase.
  - End computed at AddrW+1 bits, with no wrap. size=0 never matches.
  - Any match in the batch: lowest index in the batch wins. Register hit=1, idx and that region's cfg; go to Done.
  - No match and b is the last batch: register hit=0, idx=0, cfg=captured default; go to Done.
  - Otherwise b++ and stay in Scan.
- Done:
  - valid_o=1 for this cycle only; go to Idle.
  - hit_o, idx_o and sel_cfg_o are registered. They hold their value until the next result is registered.
- Priority: ascending scan with first-batch exit gives the globally lowest matching index.
- req_i while not ready_o is ignored; there is no queuing. The requester must hold req_i until it sees ready_o.
- region_attrs_i changes mid-scan: each beat uses the values present in that cycle. Firmware locks region cfgs before enabling protection.
- RegIdxW = max(1, $clog2(Regions)).

## Timing
- Reset values: state=Idle, ready_o=1, valid_o=0, hit_o=0, idx_o=0, sel_cfg_o='0, b=0.
- rst_i during Scan or Done:
  - Next cycle is Idle with all outputs at reset values.
  - No valid_o pulse for the aborted lookup.
- Cycle numbering: accept at cycle 0. A match in batch k (0-based) gives:
  - Scan in cycles 1..k+1.
  - valid_o in cycle k+2.
  - ready_o high again in cycle k+3.
- Latency:
  - Best case (match in batch 0): valid_o at +2.
  - Miss or last-batch match: valid_o at +N+1, with N=Regions/RegionsPerCycle.
- Throughput: one lookup per (latency+1) cycles.
- RegionsPerCycle=Regions: single-beat scan; valid_o always at +2.

## Structure
- flash_ctrl_pkg already provides data_region_attr_t, mp_region_cfg_t, flash_lcmgr_phase_e and AllPagesW. Add to it:
  - the scan-state enum flash_mp_scan_st_e.
- Sub-module flash_mp_region_cmp: a single-region comparator (addr, phase, attr -> match). It is instantiated RegionsPerCycle times on a batch mux indexed by b.
- Elaboration assertions: Regions % RegionsPerCycle == 0, and RegionsPerCycle >= 1.
- Runtime assertions:
  - valid_o never high on two consecutive cycles.
  - ready_o and valid_o never high together.

## Test plan
- Regions=8, RPC=2; region 5 {en, base=0x40, size=0x10, phase match}; addr=0x48 -> valid_o at cycle +4, hit_o=1, idx_o=5, sel_cfg_o=region 5 cfg.
- Regions 1 and 2 overlap at 0x20 (both enabled), addr=0x20 -> idx_o=1. With region 0 also covering it -> idx_o=0 at cycle +2.
- All regions disabled; default_cfg_i has a distinct pattern -> valid_o at +5, hit_o=0, idx_o=0, sel_cfg_o=default.
- Boundaries for base=0x1F0, size=0x10, AddrW=9:
  - addr=0x1FF -> hit.
  - addr=0x1EF -> miss.
  - size=0 -> miss.
  - base+size=0x200 -> no wrap, 0x000 misses.
- rst_i asserted in Scan cycle 2 -> no valid_o, ready_o=1 next cycle. A fresh request then completes normally.
- req_i held across a busy lookup -> accepted the cycle after valid_o, exactly one extra result. Repeat with RPC=Regions=4 -> every result at +2.
